// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: funct3 codes,
// FSM state encoding and the data-path width.
package dmem_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } dmem_state_e;

    // Stores have no unsigned forms, so bu/hu are only legal for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: load-side extract/extend and store-side
// byte/half merge into a full memory word. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            F3_B:    store_word[{lane, 3'b000} +: 8]    = wdata[7:0];
            F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// CPU-side load/store controller for a word-only synchronous DMem: sub-word
// loads are extended, sb/sh go through read-modify-write, bad requests never touch memory.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 14,
    parameter int unsigned CHECK_RANGE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    dmem_state_e         state_q, state_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [2:0]          f3_q, f3_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                misaligned;
    logic                out_of_range;
    logic                req_bad;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   store_word;

    dmem_lane_align u_align (
        .funct3     (f3_q),
        .lane       (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (sdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        misaligned   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                     || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        out_of_range = (CHECK_RANGE != 0) && ((req_addr >> (ADDR_W + 2)) != 32'd0);
        req_bad      = misaligned || out_of_range || !f3_legal(req_funct3, req_we);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        sdata_d = sdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W+1:0];
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    sdata_d = req_wdata;
                    err_d   = req_bad;
                    if (req_bad) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        word_d  = req_wdata;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                // mem_rdata is the word addressed during ST_RD
                if (we_q) begin
                    word_d  = store_word;
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                rdata_d = '0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            sdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            sdata_q <= sdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ready is gated by rst_n so every output reads 0 while reset is held
    assign req_ready  = rst_n && (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = err_q && (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign mem_read   = (state_q == ST_RD);
    assign mem_write  = (state_q == ST_WR);
    assign mem_addr   = 32'(addr_q[ADDR_W+1:2]);
    assign mem_wdata  = word_q;

endmodule
